uart_core: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_if.sv | 22 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_core.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transceiver.
// The parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_e;
`endif

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_if.sv
// User-side streaming byte interface of the UART: TX valid/ready input, RX pulse outputs.
interface uart_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick_c is high while the count sits at zero.
module uart_bit_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_c
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_c = (cnt_q == '0);
endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: bit-timed transmitter and mid-bit-sampling receiver with break handling.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic  clk,
  input  logic  rst,
  uart_if.slave bus,
  output logic  uart_tx,
  input  logic  uart_rx
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = clog2_min1(CLKS_PER_BIT * STOP_BITS);
  localparam int unsigned IDX_W = clog2_min1(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_load_c, tx_tick_c;
  logic [CNT_W-1:0]     tx_load_val_c;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_load_c, rx_tick_c;
  logic [CNT_W-1:0]     rx_load_val_c;

`ifdef UART_PARITY_EN
  logic tx_par_q, tx_par_d;
  logic rx_par_q, rx_par_d;
  logic rx_perr_q, rx_perr_d;
`endif

  uart_bit_timer #(.CNT_W(CNT_W)) u_tx_timer (
    .clk(clk), .rst(rst), .load(tx_load_c), .load_val(tx_load_val_c), .tick_c(tx_tick_c)
  );

  uart_bit_timer #(.CNT_W(CNT_W)) u_rx_timer (
    .clk(clk), .rst(rst), .load(rx_load_c), .load_val(rx_load_val_c), .tick_c(rx_tick_c)
  );

  // Transmit sequencing; the line value for the next bit is registered at each bit boundary.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_shift_d    = tx_shift_q;
    tx_idx_d      = tx_idx_q;
    tx_line_d     = tx_line_q;
    tx_ready_d    = tx_ready_q;
    tx_load_c     = 1'b0;
    tx_load_val_c = BIT_LD;
`ifdef UART_PARITY_EN
    tx_par_d      = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d  = 1'b1;
        tx_ready_d = 1'b1;
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
`ifdef UART_PARITY_EN
          tx_par_d   = (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
          tx_line_d  = 1'b0;
          tx_ready_d = 1'b0;
          tx_load_c  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick_c) begin
          tx_line_d  = tx_shift_q[0];
          tx_idx_d   = '0;
          tx_load_c  = 1'b1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick_c) begin
          tx_load_c = 1'b1;
          if (tx_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
            tx_line_d  = tx_par_q;
            tx_state_d = TX_PARITY;
`else
            tx_line_d     = 1'b1;
            tx_load_val_c = STOP_LD;
            tx_state_d    = TX_STOP;
`endif
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
            tx_idx_d   = tx_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick_c) begin
          tx_line_d     = 1'b1;
          tx_load_c     = 1'b1;
          tx_load_val_c = STOP_LD;
          tx_state_d    = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick_c) begin
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Receive sequencing on the synchronised line; the timer marks each mid-bit sample point.
  always_comb begin
    rx_meta_d     = uart_rx;
    rx_sync_d     = rx_meta_q;
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_idx_d      = rx_idx_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_ferr_d     = 1'b0;
    rx_load_c     = 1'b0;
    rx_load_val_c = BIT_LD;
`ifdef UART_PARITY_EN
    rx_par_d      = rx_par_q;
    rx_perr_d     = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_load_c     = 1'b1;
          rx_load_val_c = HALF_LD;
          rx_state_d    = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick_c) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_idx_d   = '0;
            rx_load_c  = 1'b1;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick_c) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load_c  = 1'b1;
          if (rx_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick_c) begin
          rx_par_d   = rx_sync_q;
          rx_load_c  = 1'b1;
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick_c) begin
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_par_q != ((^rx_shift_q) ^ 1'(PARITY_ODD));
`endif
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_load_c  = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // Any low sample restarts the one-bit-period high requirement.
        if (!rx_sync_q) begin
          rx_load_c = 1'b1;
        end else if (rx_tick_c) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_line_q  <= tx_line_d;
      tx_ready_q <= tx_ready_d;
      rx_state_q <= rx_state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign uart_tx          = tx_line_q;
  assign bus.tx_ready     = tx_ready_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = rx_perr_q;
`else
  logic unused_parity_odd_c;
  assign unused_parity_odd_c   = 1'(PARITY_ODD);
  assign bus.rx_parity_err     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-level reference model, loopback and directly driven RX.
module tb_uart_core;
  localparam int unsigned CPB  = 16;
  localparam int unsigned DB   = 8;
  localparam int unsigned SB   = 1;
  localparam int unsigned PODD = 0;
`ifdef UART_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FRAME  = (1 + DB + PB + SB) * CPB;
  localparam int unsigned RX_LAT = 2 + CPB / 2 + (DB + PB + 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  logic rx_drive = 1'b1;
  logic loop_en = 1'b0;
  logic rx_line;
  assign rx_line = loop_en ? uart_tx : rx_drive;

  uart_if #(.DATA_BITS(DB)) bus ();

  uart_core #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx), .uart_rx(rx_line)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receive monitor: every accepted byte with its cycle stamp and parity flag.
  logic [DB-1:0] rx_q[$];
  int unsigned   rx_t[$];
  bit            rx_pe[$];
  int unsigned   ferr_cnt = 0;
  int unsigned   perr_cnt = 0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rx_t.push_back(cyc);
      rx_pe.push_back(bus.rx_parity_err);
    end
    if (bus.rx_frame_err === 1'b1) ferr_cnt++;
    if (bus.rx_parity_err === 1'b1) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line level of frame bit k: start 0, data LSB first, optional parity, then stop ones.
  function automatic logic frame_bit(input logic [DB-1:0] b, input int unsigned k, input int par_force);
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    if (PB == 1 && k == DB + 1) return (par_force >= 0) ? par_force[0] : ((^b) ^ 1'(PODD));
    return 1'b1;
  endfunction

  // Send one byte on the TX side and compare every line cycle against the model.
  task automatic tx_frame(input logic [DB-1:0] b, output int unsigned t0);
    int unsigned errs;
    int unsigned low;
    errs = 0;
    low  = 0;
    @(negedge clk);
    check("tx_ready_idle", 32'(bus.tx_ready), 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.tx_valid = 1'b0;
    bus.tx_data  = DB'($urandom);
    for (int c = 0; c < int'(FRAME); c++) begin
      if (uart_tx !== frame_bit(b, c / CPB, -1)) errs++;
      if (bus.tx_ready === 1'b0) low++;
      @(negedge clk);
    end
    check("tx_bits", errs, 0);
    check("tx_ready_low", low, FRAME);
    check("tx_ready_after", 32'(bus.tx_ready), 1);
    check("tx_idle_line", 32'(uart_tx), 1);
  endtask

  // Drive a frame straight onto the RX pin with a chosen stop level.
  task automatic rx_frame(input logic [DB-1:0] b, input logic stop_val, input int par_force,
                          output int unsigned t0);
    t0 = cyc;
    for (int k = 0; k < int'(2 + DB + PB); k++) begin
      rx_drive = (k == int'(1 + DB + PB)) ? stop_val : frame_bit(b, k, par_force);
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic rx_expect(input string tag, input logic [DB-1:0] b, input int unsigned t0,
                           input logic exp_pe);
    logic [DB-1:0] d;
    int unsigned   t;
    logic          pe;
    check({tag, "_count"}, 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) begin
      d  = rx_q.pop_front();
      t  = rx_t.pop_front();
      pe = rx_pe.pop_front();
      check({tag, "_data"}, 32'(d), 32'(b));
      check({tag, "_lat"}, 32'((t - t0 + 1 >= RX_LAT) && (t - t0 <= RX_LAT + 1)), 1);
      check({tag, "_perr"}, 32'(pe), 32'(exp_pe));
    end
    rx_q.delete();
    rx_t.delete();
    rx_pe.delete();
  endtask

  initial begin
    logic [DB-1:0] b;
    logic [DB-1:0] last_rx;
    logic          expb;
    int unsigned   t0;
    int unsigned   t1;
    int unsigned   errs;
    int unsigned   ferr0;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    last_rx      = '0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_flags", 32'({bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55 over loopback: alternating line pattern and a clean reception.
    loop_en = 1'b1;
    tx_frame(8'h55, t0);
    repeat (4) @(negedge clk);
    rx_expect("loop_55", 8'h55, t0, 1'b0);

    // tx_valid held across two bytes: exactly one idle-high cycle between frames.
    @(negedge clk);
    bus.tx_data  = 8'h41;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.tx_data = 8'h42;
    errs = 0;
    for (int c = 0; c < int'(2 * FRAME + 1); c++) begin
      if (c < int'(FRAME))       expb = frame_bit(8'h41, c / CPB, -1);
      else if (c == int'(FRAME)) expb = 1'b1;
      else                       expb = frame_bit(8'h42, (c - FRAME - 1) / CPB, -1);
      if (uart_tx !== expb) errs++;
      if (c == int'(FRAME)) check("b2b_ready_gap", 32'(bus.tx_ready), 1);
      if (c == int'(FRAME + 1)) bus.tx_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_bits", errs, 0);
    check("b2b_rx_count", 32'(rx_q.size()), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx_first", 32'(rx_q[0]), 32'h41);
      check("b2b_rx_second", 32'(rx_q[1]), 32'h42);
    end
    rx_q.delete(); rx_t.delete(); rx_pe.delete();
    last_rx = 8'h42;

    // Short low glitch is rejected, then a real frame is received.
    loop_en  = 1'b0;
    rx_drive = 1'b1;
    repeat (4) @(negedge clk);
    rx_drive = 1'b0;
    repeat (5) @(negedge clk);
    rx_drive = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_rx", 32'(rx_q.size()), 0);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_keep_data", 32'(bus.rx_data), 32'(last_rx));
    rx_frame(8'hA3, 1'b1, -1, t0);
    repeat (4) @(negedge clk);
    rx_expect("rx_a3", 8'hA3, t0, 1'b0);
    last_rx = 8'hA3;

    // Stop bit low followed by a held break.
    rx_frame(8'h3C, 1'b0, -1, t0);
    repeat (40) @(negedge clk);
    check("ferr_one_pulse", ferr_cnt, 1);
    check("ferr_no_rx", 32'(rx_q.size()), 0);
    check("ferr_keep_data", 32'(bus.rx_data), 32'(last_rx));
    // Line high for less than a bit: an all-ones frame is swallowed by the break wait.
    rx_drive = 1'b1;
    repeat (8) @(negedge clk);
    rx_frame(8'hFF, 1'b1, -1, t0);
    repeat (40) @(negedge clk);
    check("break_hold_no_rx", 32'(rx_q.size()), 0);
    check("break_hold_no_ferr", ferr_cnt, 1);
    rx_frame(8'h96, 1'b1, -1, t0);
    repeat (4) @(negedge clk);
    rx_expect("after_break", 8'h96, t0, 1'b0);
    last_rx = 8'h96;

`ifdef UART_PARITY_EN
    rx_frame(8'h07, 1'b1, 0, t0);
    repeat (4) @(negedge clk);
    rx_expect("par_bad", 8'h07, t0, 1'b1);
    rx_frame(8'h07, 1'b1, 1, t0);
    repeat (4) @(negedge clk);
    rx_expect("par_good", 8'h07, t0, 1'b0);
    check("par_err_pulses", perr_cnt, 1);
    last_rx = 8'h07;
`else
    check("no_par_err_pulses", perr_cnt, 0);
`endif

    // Random bytes, alternating loopback TX and directly driven RX with random gaps.
    for (int i = 0; i < 8; i++) begin
      b = DB'($urandom);
      if (($urandom % 2) == 0) begin
        loop_en = 1'b1;
        tx_frame(b, t0);
        repeat (4) @(negedge clk);
        rx_expect("rand_loop", b, t0, 1'b0);
      end else begin
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx_frame(b, 1'b1, -1, t0);
        repeat (4) @(negedge clk);
        rx_expect("rand_rx", b, t0, 1'b0);
      end
      last_rx = b;
    end
    check("rand_rx_data_hold", 32'(bus.rx_data), 32'(last_rx));

    // Reset in the middle of data bit 3 aborts the frame at once.
    loop_en  = 1'b1;
    ferr0    = ferr_cnt;
    b        = DB'($urandom) & ~DB'(8);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("mid_bit3_line", 32'(uart_tx), 32'(frame_bit(b, 4, -1)));
    rst = 1'b1;
    #1;
    check("rst_mid_uart_tx", 32'(uart_tx), 1);
    check("rst_mid_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_mid_rx_data", 32'(bus.rx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    last_rx = '0;
    repeat (3 * CPB) @(negedge clk);
    check("rst_mid_no_rx", 32'(rx_q.size()), 0);
    check("rst_mid_no_ferr", ferr_cnt, ferr0);
    b = DB'($urandom);
    tx_frame(b, t1);
    repeat (4) @(negedge clk);
    rx_expect("post_rst", b, t1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
